// File: rtl/mips_pkg.sv
// Shared datapath widths and packer FSM state encodings for the
// immediate-handling blocks.
package mips_pkg;

   localparam int WORD_WIDTH = 32;
   localparam int IMM_WIDTH  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_RESP = 2'd2
   } packer_state_t;

endpackage : mips_pkg

// File: rtl/imm_chunk_cmp.sv
// Combinational check of one slice of upper bits against the replicated
// extension reference bit.
module imm_chunk_cmp #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] bits,
   input  logic             ref_bit,
   output logic             mismatch
);

   assign mismatch = (bits != {CHUNK{ref_bit}});

endmodule : imm_chunk_cmp

// File: rtl/imm_narrow_packer.sv
// Narrows a word to an immediate field and reports whether sign/zero extension
// of that field reproduces the word; the upper bits are checked CHUNK per clock.
module imm_narrow_packer
   import mips_pkg::*;
#(
   parameter int IN_WIDTH  = WORD_WIDTH,
   parameter int OUT_WIDTH = IMM_WIDTH,
   parameter int CHUNK     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_word,
   input  logic                 in_unsigned,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_imm,
   output logic                 out_fits
);

   localparam int UPPER_W = IN_WIDTH - OUT_WIDTH;
   localparam int NCHUNK  = (CHUNK > 0) ? (UPPER_W / CHUNK) : 1;
   localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

   generate
      if (OUT_WIDTH < 1 || UPPER_W < 1 || CHUNK < 1 || (UPPER_W % CHUNK) != 0) begin : g_bad_params
         $error("imm_narrow_packer: illegal IN_WIDTH/OUT_WIDTH/CHUNK combination");
      end
   endgenerate

   packer_state_t        state;
   logic [UPPER_W-1:0]   upper;
   logic [OUT_WIDTH-1:0] field;
   logic                 ref_bit;
   logic                 err;
   logic [CNT_W-1:0]     cnt;
   logic                 mismatch;

   // The upper bits are shifted down each SCAN cycle, so the comparator
   // always looks at the lowest slice instead of a variable part-select.
   imm_chunk_cmp #(
      .CHUNK (CHUNK)
   ) u_cmp (
      .bits     (upper[CHUNK-1:0]),
      .ref_bit  (ref_bit),
      .mismatch (mismatch)
   );

   // Handshake FSM, scan counter, sticky error and registered result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         upper     <= '0;
         field     <= '0;
         ref_bit   <= 1'b0;
         err       <= 1'b0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_fits  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  upper    <= in_word[IN_WIDTH-1:OUT_WIDTH];
                  field    <= in_word[OUT_WIDTH-1:0];
                  ref_bit  <= in_unsigned ? 1'b0 : in_word[OUT_WIDTH-1];
                  err      <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_SCAN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ST_SCAN: begin
               err   <= err | mismatch;
               upper <= upper >> CHUNK;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  // Fold in the final slice so the result is ready on RESP entry.
                  out_valid <= 1'b1;
                  out_imm   <= field;
                  out_fits  <= ~(err | mismatch);
                  state     <= ST_RESP;
               end else begin
                  state <= ST_SCAN;
               end
            end
            ST_RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_RESP;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : imm_narrow_packer

// File: tb/tb_imm_narrow_packer.sv
// Directed and randomized checks of imm_narrow_packer against a value-range
// reference model.
module tb_imm_narrow_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_word = 32'd0;
   logic        in_unsigned = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [5:0]  out_imm;
   logic        out_fits;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_narrow_packer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_word     (in_word),
      .in_unsigned (in_unsigned),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fits    (out_fits)
   );

   // A word fits when its numeric value lies in the 6-bit range of the mode.
   function automatic logic fits_ref(input logic [31:0] w, input logic uns);
      if (uns) return (w < 32'd64);
      else     return ($signed(w) >= -32'sd32) && ($signed(w) <= 32'sd31);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Send one word, wait for the result, optionally stall the consumer.
   task automatic run_word(input string tag, input logic [31:0] w, input logic uns,
                           input int hold, input logic chk_lat);
      int          lat;
      int          waited;
      logic [5:0]  e_imm;
      logic        e_fits;
      e_imm  = w[5:0];
      e_fits = fits_ref(w, uns);
      waited = 0;
      while (!in_ready && waited < 40) begin
         @(posedge clk); @(negedge clk); waited++;
      end
      check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
      in_word = w; in_unsigned = uns; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      in_word = $urandom;
      in_unsigned = ~uns;
      lat = 1;
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      while (!out_valid && lat < 40) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'd14);
      check({tag, "_imm"}, 32'(out_imm), 32'(e_imm));
      check({tag, "_fits"}, 32'(out_fits), 32'(e_fits));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_imm"}, 32'(out_imm), 32'(e_imm));
         check({tag, "_hold_fits"}, 32'(out_fits), 32'(e_fits));
         check({tag, "_hold_inready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_done_inready"}, 32'(in_ready), 32'd1);
      check({tag, "_kept_imm"}, 32'(out_imm), 32'(e_imm));
      check({tag, "_kept_fits"}, 32'(out_fits), 32'(e_fits));
   endtask

   initial begin
      logic [31:0] w;
      logic [5:0]  v;
      int          seen;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_imm", 32'(out_imm), 32'd0);
      check("rst_out_fits", 32'(out_fits), 32'd0);

      run_word("s_1f",       32'h0000_001F, 1'b0, 0, 1'b1);
      run_word("s_ffffffe0", 32'hFFFF_FFE0, 1'b0, 0, 1'b1);
      run_word("u_ffffffe0", 32'hFFFF_FFE0, 1'b1, 0, 1'b1);
      run_word("s_20",       32'h0000_0020, 1'b0, 0, 1'b1);
      run_word("u_20",       32'h0000_0020, 1'b1, 0, 1'b1);
      run_word("s_80000005", 32'h8000_0005, 1'b0, 0, 1'b1);
      run_word("u_3f",       32'h0000_003F, 1'b1, 0, 1'b1);
      run_word("u_40",       32'h0000_0040, 1'b1, 0, 1'b1);
      run_word("s_ffffffdf", 32'hFFFF_FFDF, 1'b0, 0, 1'b1);
      run_word("stall10",    32'hFFFF_FFF3, 1'b0, 10, 1'b1);

      // Reset while the scan counter sits at 5 must drop the word.
      in_word = 32'h0000_0011; in_unsigned = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_result", 32'(seen), 32'd0);

      for (int i = 0; i < 64; i++) begin
         v = 6'(i);
         w = {{26{v[5]}}, v};
         run_word("roundtrip", w, 1'b0, 0, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         case ($urandom_range(0, 2))
            0:       w[31:6] = 26'h0;
            1:       w[31:6] = 26'h3FF_FFFF;
            default: w[31:6] = w[31:6];
         endcase
         if ($urandom_range(0, 3) == 0) w[31 - $urandom_range(0, 25)] ^= 1'b1;
         run_word("random", w, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_imm_narrow_packer
